// File: rtl/axis_frame_capture_if.sv
// AXI-Stream sample-packet bus: SAMP_PER_CLK samples of SAMP_W bits per beat.
interface alpaca_data_pkt_axis #(
  parameter int unsigned SAMP_PER_CLK = 2,
  parameter int unsigned SAMP_W       = 16
) ();
  logic [SAMP_PER_CLK*SAMP_W-1:0] tdata;
  logic                           tvalid;
  logic                           tready;
  logic                           tlast;
  logic                           tuser;

  modport MST (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport SLV (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_frame_capture.sv
// Frame-aligned AXI-Stream capture sink with arm/re-arm, frame decimation,
// one-shot or ring storage, tlast framing checks and registered readback.
module axis_frame_capture #(
  parameter int unsigned FFT_LEN      = 32,
  parameter int unsigned SAMP_PER_CLK = 2,
  parameter int unsigned FRAMES       = 2,
  parameter int unsigned SAMP_W       = 16,
  localparam int unsigned DEPTH       = FRAMES*FFT_LEN/SAMP_PER_CLK,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned DW          = SAMP_PER_CLK*SAMP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  alpaca_data_pkt_axis.SLV     s_axis,
  input  logic                 arm,
  input  logic                 continuous,
  input  logic [7:0]           skip,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 full,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic                 tlast_err
);

  localparam int unsigned    BPF      = FFT_LEN/SAMP_PER_CLK;
  localparam int unsigned    BW       = $clog2(BPF);
  localparam logic [BW-1:0]  BCNT_MAX = BW'(BPF-1);

  typedef enum logic [2:0] {IDLE, SYNC, CAPTURE, SKIP, DONE} state_t;

  state_t          r_state;
  logic [BW-1:0]   r_bcnt;
  logic [7:0]      r_scnt;
  logic [7:0]      r_skip;
  logic            r_cont;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_fbase;
  logic [15:0]     r_frame_cnt;
  logic            r_full;
  logic            r_tlast_err;
  logic [DW-1:0]   r_rd_data;
  logic [DW-1:0]   r_ram [DEPTH];

  logic            w_accept;
  logic            w_last_beat;
  logic            w_frame_err;
  logic            w_fill;
  logic            w_we;
  logic [15:0]     w_cnt_inc;

  assign s_axis.tready = ~rst;
  assign w_accept      = s_axis.tvalid & s_axis.tready;
  assign w_last_beat   = (r_bcnt == BCNT_MAX);
  assign w_frame_err   = s_axis.tlast ^ w_last_beat;
  assign w_cnt_inc     = (r_frame_cnt == 16'hFFFF) ? r_frame_cnt : r_frame_cnt + 16'd1;
  assign w_fill        = r_full | (({1'b0, r_frame_cnt} + 17'd1) == 17'(FRAMES));
  assign w_we          = ~rst & ~arm & w_accept & (r_state == CAPTURE);

  // Capture FSM with beat/skip counters, write pointer and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bcnt      <= '0;
      r_scnt      <= '0;
      r_skip      <= '0;
      r_cont      <= 1'b0;
      r_wptr      <= '0;
      r_fbase     <= '0;
      r_frame_cnt <= '0;
      r_full      <= 1'b0;
      r_tlast_err <= 1'b0;
    end else if (arm) begin
      r_state     <= SYNC;
      r_bcnt      <= '0;
      r_scnt      <= '0;
      r_skip      <= skip;
      r_cont      <= continuous;
      r_wptr      <= '0;
      r_fbase     <= '0;
      r_frame_cnt <= '0;
      r_full      <= 1'b0;
      r_tlast_err <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        SYNC: begin
          if (s_axis.tlast) begin
            r_bcnt <= '0;
            if (r_skip == 8'd0) begin
              r_state <= CAPTURE;
            end else begin
              r_state <= SKIP;
              r_scnt  <= r_skip;
            end
          end
        end
        CAPTURE, SKIP: begin
          if (w_frame_err) begin
            // Drop the partial frame; a tlast on the offending beat already
            // marks a frame boundary, so resynchronise on it directly.
            r_tlast_err <= 1'b1;
            r_wptr      <= r_fbase;
            r_bcnt      <= '0;
            if (!s_axis.tlast) begin
              r_state <= SYNC;
            end else if (r_skip == 8'd0) begin
              r_state <= CAPTURE;
            end else begin
              r_state <= SKIP;
              r_scnt  <= r_skip;
            end
          end else if (w_last_beat) begin
            r_bcnt <= '0;
            if (r_state == CAPTURE) begin
              r_wptr      <= r_wptr + 1'b1;
              r_fbase     <= r_wptr + 1'b1;
              r_frame_cnt <= w_cnt_inc;
              r_full      <= w_fill;
              if (!r_cont && w_fill) begin
                r_state <= DONE;
              end else if (r_skip != 8'd0) begin
                r_state <= SKIP;
                r_scnt  <= r_skip;
              end else begin
                r_state <= CAPTURE;
              end
            end else begin
              r_scnt <= r_scnt - 8'd1;
              if (r_scnt <= 8'd1) begin
                r_state <= CAPTURE;
              end
            end
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
            if (r_state == CAPTURE) begin
              r_wptr <= r_wptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Frame storage write port
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_ram[r_wptr] <= s_axis.tdata;
    end
  end

  // Registered readback; same-address write returns old data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_ram[rd_addr];
    end
  end

  assign rd_data   = r_rd_data;
  assign full      = r_full;
  assign busy      = (r_state == SYNC) || (r_state == CAPTURE) || (r_state == SKIP);
  assign frame_cnt = r_frame_cnt;
  assign tlast_err = r_tlast_err;

endmodule

// File: tb/tb_axis_frame_capture.sv
// Self-checking bench for axis_frame_capture: random frame data, frame-level
// reference model of sync/skip/store/ring behaviour, directed scenario steps.
module tb_axis_frame_capture;

  localparam int unsigned FFT_LEN = 32;
  localparam int unsigned SPC     = 2;
  localparam int unsigned FRAMES  = 2;
  localparam int unsigned SW      = 16;
  localparam int unsigned BPF     = FFT_LEN/SPC;
  localparam int unsigned AW      = 5;
  localparam int unsigned DW      = SPC*SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          continuous = 1'b0;
  logic [7:0]    skip = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          tlast_err;

  alpaca_data_pkt_axis #(.SAMP_PER_CLK(SPC), .SAMP_W(SW)) axis ();

  axis_frame_capture #(
    .FFT_LEN(FFT_LEN), .SAMP_PER_CLK(SPC), .FRAMES(FRAMES), .SAMP_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .s_axis(axis), .arm(arm), .continuous(continuous),
    .skip(skip), .rd_addr(rd_addr), .rd_data(rd_data), .full(full),
    .busy(busy), .frame_cnt(frame_cnt), .tlast_err(tlast_err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src [32][20];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model state (frame granularity)
  bit m_cont;
  int m_skip, m_skipleft, m_cnt;
  bit m_synced, m_full, m_err, m_done;
  int exp_slot [FRAMES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_arm(input bit cont, input int skp);
    m_cont = cont; m_skip = skp; m_skipleft = 0; m_cnt = 0;
    m_synced = 0; m_full = 0; m_err = 0; m_done = 0;
  endtask

  // one complete tlast-delimited frame has been delivered to the DUT
  task automatic m_frame_end(input int idx, input bit clean);
    if (!m_synced) begin
      m_synced = 1; m_skipleft = m_skip;
    end else if (m_done) begin
    end else if (!clean) begin
      m_err = 1; m_skipleft = m_skip;
    end else if (m_skipleft > 0) begin
      m_skipleft--;
    end else begin
      exp_slot[m_cnt % FRAMES] = idx;
      m_cnt++;
      if (m_cnt >= FRAMES) m_full = 1;
      if (!m_cont && m_full) m_done = 1;
      m_skipleft = m_skip;
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
    chk({tag, ".full"},      32'(full),      32'(m_full));
    chk({tag, ".tlast_err"}, 32'(tlast_err), 32'(m_err));
    chk({tag, ".busy"},      32'(busy),      32'(!m_done));
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit last, input bit gappy);
    if (gappy) begin
      while ($urandom_range(0, 99) >= 30) begin
        @(posedge clk); #1;
      end
    end
    axis.tvalid = 1'b1;
    axis.tdata  = d;
    axis.tlast  = last;
    axis.tuser  = 1'($urandom);
    @(posedge clk); #1;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
  endtask

  // beats b0..nb-1 of source frame idx, tlast on the final one
  task automatic send_range(input string tag, input int idx, input int b0, input int nb, input bit gappy);
    for (int b = b0; b < nb; b++) beat(src[idx][b], (b == nb-1), gappy);
    m_frame_end(idx, (b0 == 0) && (nb == BPF));
    check_status(tag);
  endtask

  task automatic do_arm(input string tag, input bit cont, input int skp);
    continuous = cont;
    skip       = 8'(skp);
    arm        = 1'b1;
    @(posedge clk); #1;
    arm        = 1'b0;
    continuous = $urandom_range(0, 1) != 0;
    skip       = 8'($urandom);
    m_arm(cont, skp);
    check_status(tag);
  endtask

  task automatic check_ram(input string tag);
    int n;
    n = (m_cnt < FRAMES) ? m_cnt : FRAMES;
    for (int s = 0; s < n; s++) begin
      for (int b = 0; b < BPF; b++) begin
        rd_addr = AW'(s*BPF + b);
        @(posedge clk); #1;
        chk(tag, rd_data, src[exp_slot[s]][b]);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".tready"},    32'(axis.tready), 32'd0);
    chk({tag, ".full"},      32'(full),        32'd0);
    chk({tag, ".busy"},      32'(busy),        32'd0);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt),   32'd0);
    chk({tag, ".tlast_err"}, 32'(tlast_err),   32'd0);
    chk({tag, ".rd_data"},   rd_data,          32'd0);
  endtask

  initial begin
    logic [15:0] s0, s1;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;
    axis.tdata  = '0;

    for (int f = 0; f < 32; f++)
      for (int b = 0; b < 20; b++) src[f][b] = $urandom;
    // impulse source: sample 2 = 256, sample 0 tags the frame
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < BPF; b++) begin
        s0 = (b*2 == 2) ? 16'd256 : ((b == 0) ? 16'(f + 1) : 16'd0);
        s1 = (b*2 + 1 == 2) ? 16'd256 : 16'd0;
        src[f][b] = {s1, s0};
      end

    // reset
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("tready_after_reset", 32'(axis.tready), 32'd1);

    // one-shot: arm mid-frame, the in-flight partial frame is dropped
    for (int b = 0; b < 5; b++) beat(src[0][b], 1'b0, 1'b0);
    do_arm("os.arm", 1'b0, 0);
    send_range("os.f0", 0, 5, BPF, 1'b0);
    send_range("os.f1", 1, 0, BPF, 1'b0);
    send_range("os.f2", 2, 0, BPF, 1'b0);
    send_range("os.f3", 3, 0, BPF, 1'b0);
    check_ram("os.ram");

    // skip = 2: stored frames are k and k+3
    do_arm("skip.arm", 1'b0, 2);
    for (int f = 4; f < 12; f++) send_range("skip.f", f, 0, BPF, 1'b0);
    check_ram("skip.ram");

    // continuous ring, 5 stored frames
    do_arm("ring.arm", 1'b1, 0);
    for (int f = 12; f < 18; f++) send_range("ring.f", f, 0, BPF, 1'b0);
    chk("ring.slot0_frame", 32'(exp_slot[0]), 32'd17);
    check_ram("ring.ram");

    // framing errors: early tlast at beat 7, then missing tlast at beat 15
    do_arm("err.arm", 1'b0, 0);
    send_range("err.sync", 18, 0, BPF, 1'b0);
    send_range("err.early", 19, 0, 8, 1'b0);
    send_range("err.clean0", 20, 0, BPF, 1'b0);
    send_range("err.late", 21, 0, 20, 1'b0);
    send_range("err.clean1", 22, 0, BPF, 1'b0);
    check_ram("err.ram");

    // gappy tvalid, same source as the one-shot case
    do_arm("gap.arm", 1'b0, 0);
    send_range("gap.f0", 0, 0, BPF, 1'b1);
    send_range("gap.f1", 1, 0, BPF, 1'b1);
    send_range("gap.f2", 2, 0, BPF, 1'b1);
    check_ram("gap.ram");

    // reset mid-capture, then re-arm
    do_arm("rst.arm", 1'b0, 0);
    send_range("rst.sync", 23, 0, BPF, 1'b0);
    for (int b = 0; b < 6; b++) beat(src[24][b], 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rst.mid");
    rst = 1'b0;
    do_arm("rst.rearm", 1'b0, 0);
    send_range("rst.f25", 25, 0, BPF, 1'b0);
    send_range("rst.f26", 26, 0, BPF, 1'b0);
    send_range("rst.f27", 27, 0, BPF, 1'b0);
    check_ram("rst.ram");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_frame_capture.md
# axis_frame_capture

Frame-aligned AXI-Stream capture sink for simulation and on-chip debug of the parallel FFT datapath; successor to the fixed-depth `axis_vip` capture. It sits on `m_axis_Xk` (or any `alpaca_data_pkt_axis` stream) and stores whole `FFT_LEN`-sample frames, aligned on `tlast`. Compared with `axis_vip`, it adds arm/re-arm, frame decimation, a one-shot or continuous ring mode, `tlast` framing checks and a registered readback port.

## Interface
- `FFT_LEN`, 32: samples per frame; power of two, ≥ `2*SAMP_PER_CLK`.
- `SAMP_PER_CLK`, 2: samples per beat; power of two.
- `FRAMES`, 2: frames stored; power of two.
- `DEPTH`, derived: `FRAMES*FFT_LEN/SAMP_PER_CLK` beats; `AW=$clog2(DEPTH)`.
- `clk`  in  1  clock.
- `rst`  in  1  **one clock; reset is synchronous and active-high.**
- `s_axis`  `alpaca_data_pkt_axis.SLV`  interface  input stream; `tdata` is `SAMP_PER_CLK` samples of `dtype`; `tuser` is ignored.
- `arm`  in  1  single-cycle pulse; starts or restarts a capture.
- `continuous`  in  1  0 = one-shot, 1 = ring; sampled when `arm` is pulsed.
- `skip`  in  8  number of frames discarded between stored frames; sampled when `arm` is pulsed.
- `rd_addr`  in  AW  beat address for readback.
- `rd_data`  out  `SAMP_PER_CLK` × `dtype`  beat stored at `rd_addr`.
- `full`  out  1  `FRAMES` frames have been stored since the last arm.
- `busy`  out  1  FSM is not in IDLE or DONE.
- `frame_cnt`  out  16  frames stored since arm; saturates at `0xFFFF`.
- `tlast_err`  out  1  sticky framing error; cleared by `arm` or `rst`.

## Operation
- `s_axis.tready` is 0 during `rst` and 1 otherwise. The block never back-pressures; beats that are not stored are dropped.
- A beat is accepted on `tvalid & tready`. Beat counter `bcnt` runs from 0 to `FFT_LEN/SAMP_PER_CLK-1`. Skip counter is `scnt`. Write pointer is `wptr` (AW bits).
- FSM states:
  - IDLE: entered on reset; ignores the stream.
  - `arm` → SYNC: clears `wptr`, `frame_cnt`, `full` and `tlast_err`; latches `continuous` and `skip`.
  - SYNC: waits for an accepted beat with `tlast=1`. This discards the partial frame in flight at arm time. On that beat, go to CAPTURE if `skip==0`, otherwise go to SKIP with `scnt=skip`.
  - CAPTURE: writes each accepted beat to `ram[wptr]` and increments `wptr` (wrapping at `DEPTH`). At the final beat (`bcnt` = max):
    - if `tlast=1`: the frame is committed and `frame_cnt` increments;
    - if `frame_cnt+1 == FRAMES`, `full` is set;
    - then go to DONE if one-shot and `full`; otherwise go to SKIP when `skip≠0`, or stay in CAPTURE when `skip==0`.
  - SKIP: counts whole frames (on `bcnt`=max with `tlast=1`) and decrements `scnt`. When `scnt` reaches 0, go to CAPTURE.
  - DONE: holds the stored contents. `arm` re-enters SYNC.
- Framing error (CAPTURE or SKIP): either of these sets `tlast_err`:
  - `tlast=1` with `bcnt` ≠ max;
  - `tlast=0` with `bcnt` = max.
- On a framing error:
  - `wptr` rewinds to the start of the current frame, so the partial frame is never committed;
  - `bcnt` clears and the FSM returns to SYNC;
  - if the offending beat carried `tlast`, SYNC is treated as satisfied on that beat.
- Continuous mode:
  - `full` stays 1 once set; the ring overwrites the oldest frame.
  - The most recent committed frame starts at `((frame_cnt-1) mod FRAMES)*FFT_LEN/SAMP_PER_CLK`.
- `arm` arriving in any state (including mid-frame) restarts from SYNC. The RAM is not cleared.

## Timing
- Reset values:
  - `tready=0`, `full=0`, `busy=0`, `frame_cnt=0`, `tlast_err=0`;
  - `rd_data=0`;
  - FSM = IDLE; all counters 0.
- `arm` at edge N: `busy=1` from N+1; beats accepted at N+1 are already evaluated in SYNC.
- Write latency: an accepted beat at edge N is readable at `rd_addr` from N+1.
- `rd_data` is registered: the value for `rd_addr` sampled at edge N is valid after edge N (1-cycle latency). A read and a write to the same address in the same cycle returns the old data.
- `full` and `frame_cnt` update on the same edge that accepts the final beat of the frame. `tlast_err` asserts on the edge that accepts the offending beat.
- `rst` mid-capture: on the next edge all outputs and state return to reset values. The RAM is not cleared.

## Test plan
- **One-shot:**
  - Stimulus: `FFT_LEN=32`, `SAMP_PER_CLK=2`, `FRAMES=2`; impulse source (phase 2, value 256) streaming with `tlast` every 16 beats; `arm` pulsed mid-frame.
  - Required response: the first partial frame is dropped; `full=1` after 32 stored beats; `frame_cnt=2`; readback equals the source frames bit-exactly; state DONE; later beats leave the RAM unchanged.
- **Skip:**
  - Stimulus: `skip=2` on a frame-counter ramp source.
  - Required response: stored frames are source frames k and k+3.
- **Continuous ring:**
  - Stimulus: 5 frames streamed.
  - Required response: `frame_cnt=5`, `full=1`; `ram[0..15]` holds frame 4 and `ram[16..31]` holds frame 3.
- **Framing error:**
  - Stimulus: `tlast` injected at beat 7 of a frame.
  - Required response: `tlast_err=1` on that edge; the frame is not counted; `wptr` rewinds; the next clean frame is stored at the same base address.
- **Gappy tvalid:**
  - Stimulus: random `tvalid` at 30% duty.
  - Required response: captured content is identical to the gap-free case.
- **Reset and re-arm:**
  - Stimulus: `rst` asserted mid-capture for 1 cycle, then `arm`.
  - Required response: reset values are reached on the next edge; the capture completes normally after re-arm.
